// File: rtl/debug_pkg.sv
// Shared encodings for the debug memory arbiter: FSM states, access
// opcodes and counter widths.
package debug_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PEND   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

    localparam int STARVE_W = 8;
    localparam int LAT_W    = 4;

endpackage

// File: rtl/arb_port_mux.sv
// One memory port's mux: the CPU drives the port unless the debug access
// currently owns it.
module arb_port_mux #(
    parameter int ADDR_W = 10
) (
    input  logic              own_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [31:0]       dbg_wdata_i,
    input  logic              dbg_we_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              mem_we_o
);

    assign mem_addr_o  = own_i ? dbg_addr_i  : cpu_addr_i;
    assign mem_wdata_o = own_i ? dbg_wdata_i : cpu_wdata_i;
    assign mem_we_o    = own_i ? dbg_we_i    : cpu_we_i;

endmodule

// File: rtl/debug_mem_arbiter.sv
// Shares the imem/dmem ports between the CPU and the UART debug monitor,
// sequencing single-word debug accesses and stalling the CPU as needed.
module debug_mem_arbiter
    import debug_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       dbg_addr,
    input  logic [31:0]       dbg_wdata,
    input  logic              dbg_rd_req,
    input  logic              dbg_wr_req,
    input  logic              dbg_sel_imem,
    output logic [31:0]       dbg_rdata,
    output logic              dbg_rdata_valid,
    output logic              dbg_wr_done,
    output logic              dbg_busy,
    input  logic [ADDR_W-1:0] cpu_imem_addr,
    output logic [31:0]       cpu_imem_rdata,
    input  logic [ADDR_W-1:0] cpu_dmem_addr,
    input  logic [31:0]       cpu_dmem_wdata,
    input  logic              cpu_dmem_we,
    input  logic              cpu_dmem_re,
    output logic [31:0]       cpu_dmem_rdata,
    output logic              cpu_stall,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              imem_we,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    output logic              dmem_we,
    input  logic [31:0]       dmem_rdata
);

    localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(MEM_LATENCY - 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_e                state_q, state_d;
    op_e                   op_q, op_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  sel_imem_q, sel_imem_d;
    logic [STARVE_W-1:0]   starve_q, starve_d;
    logic [LAT_W-1:0]      lat_q, lat_d;
    logic [31:0]           rdata_q, rdata_d;

    logic cpu_dmem_active;
    logic starved;
    logic in_access;
    logic dbg_we;
    logic unused_addr_bits;

    assign cpu_dmem_active  = cpu_dmem_we | cpu_dmem_re;
    assign starved          = (starve_q == STARVE_MAX);
    assign in_access        = (state_q == ST_ACCESS);
    assign dbg_we           = in_access && (op_q == OP_WR) && (lat_q == '0);
    assign unused_addr_bits = ^{dbg_addr[31:ADDR_W+2], dbg_addr[1:0]};

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= OP_RD;
            addr_q     <= '0;
            wdata_q    <= '0;
            sel_imem_q <= 1'b0;
            starve_q   <= '0;
            lat_q      <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            sel_imem_q <= sel_imem_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            rdata_q    <= rdata_d;
        end
    end

    // NOTE: every next-state variable is defaulted before the case so no
    // path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_imem_d = sel_imem_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (dbg_rd_req || dbg_wr_req) begin
                    addr_d     = dbg_addr[ADDR_W+1:2];
                    wdata_d    = dbg_wdata;
                    sel_imem_d = dbg_sel_imem;
                    op_d       = dbg_wr_req ? OP_WR : OP_RD;
                    state_d    = ST_PEND;
                end
            end
            ST_PEND: begin
                // imem is never written by the CPU, so it is granted at once.
                if (sel_imem_q || !cpu_dmem_active || starved) begin
                    state_d  = ST_ACCESS;
                    starve_d = '0;
                    lat_d    = '0;
                end else if (!starved) begin
                    starve_d = starve_q + STARVE_W'(1);
                end
            end
            ST_ACCESS: begin
                if (lat_q == LAT_LAST) begin
                    state_d = ST_RESP;
                    if (op_q == OP_RD) begin
                        rdata_d = sel_imem_q ? imem_rdata : dmem_rdata;
                    end
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign dbg_busy        = (state_q != ST_IDLE);
    assign dbg_rdata       = rdata_q;
    assign dbg_rdata_valid = (state_q == ST_RESP) && (op_q == OP_RD);
    assign dbg_wr_done     = (state_q == ST_RESP) && (op_q == OP_WR);

    // The PEND term freezes the CPU on the cycle it loses a starved dmem.
    assign cpu_stall = (in_access && (sel_imem_q || cpu_dmem_active))
                     || ((state_q == ST_PEND) && !sel_imem_q && starved && cpu_dmem_active);

    assign cpu_imem_rdata = imem_rdata;
    assign cpu_dmem_rdata = dmem_rdata;

    arb_port_mux #(.ADDR_W(ADDR_W)) u_imem_mux (
        .own_i       (in_access && sel_imem_q),
        .cpu_addr_i  (cpu_imem_addr),
        .cpu_wdata_i (32'h0),
        .cpu_we_i    (1'b0),
        .dbg_addr_i  (addr_q),
        .dbg_wdata_i (wdata_q),
        .dbg_we_i    (dbg_we),
        .mem_addr_o  (imem_addr),
        .mem_wdata_o (imem_wdata),
        .mem_we_o    (imem_we)
    );

    arb_port_mux #(.ADDR_W(ADDR_W)) u_dmem_mux (
        .own_i       (in_access && !sel_imem_q),
        .cpu_addr_i  (cpu_dmem_addr),
        .cpu_wdata_i (cpu_dmem_wdata),
        .cpu_we_i    (cpu_dmem_we),
        .dbg_addr_i  (addr_q),
        .dbg_wdata_i (wdata_q),
        .dbg_we_i    (dbg_we),
        .mem_addr_o  (dmem_addr),
        .mem_wdata_o (dmem_wdata),
        .mem_we_o    (dmem_we)
    );

endmodule

// File: tb/tb_debug_mem_arbiter.sv
// Bench for debug_mem_arbiter: directed table, reset abort sequence and
// randomized transactions against a timeline model of the arbitration rules.
module tb_debug_mem_arbiter;

    localparam int AW    = 10;
    localparam int LAT   = 1;
    localparam int LIMIT = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   dbg_addr, dbg_wdata, dbg_rdata;
    logic          dbg_rd_req, dbg_wr_req, dbg_sel_imem;
    logic          dbg_rdata_valid, dbg_wr_done, dbg_busy;
    logic [AW-1:0] cpu_imem_addr, cpu_dmem_addr;
    logic [31:0]   cpu_imem_rdata, cpu_dmem_wdata, cpu_dmem_rdata;
    logic          cpu_dmem_we, cpu_dmem_re, cpu_stall;
    logic [AW-1:0] imem_addr, dmem_addr;
    logic [31:0]   imem_wdata, imem_rdata, dmem_wdata, dmem_rdata;
    logic          imem_we, dmem_we;

    always #5 clk = ~clk;

    debug_mem_arbiter #(.ADDR_W(AW), .MEM_LATENCY(LAT), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rd_req(dbg_rd_req), .dbg_wr_req(dbg_wr_req), .dbg_sel_imem(dbg_sel_imem),
        .dbg_rdata(dbg_rdata), .dbg_rdata_valid(dbg_rdata_valid),
        .dbg_wr_done(dbg_wr_done), .dbg_busy(dbg_busy),
        .cpu_imem_addr(cpu_imem_addr), .cpu_imem_rdata(cpu_imem_rdata),
        .cpu_dmem_addr(cpu_dmem_addr), .cpu_dmem_wdata(cpu_dmem_wdata),
        .cpu_dmem_we(cpu_dmem_we), .cpu_dmem_re(cpu_dmem_re),
        .cpu_dmem_rdata(cpu_dmem_rdata), .cpu_stall(cpu_stall),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .imem_we(imem_we), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata)
    );

    // Block RAM models with combinational read; unwritten words hold a
    // fixed address-derived pattern.
    logic [31:0] imem_mem [1024];
    logic [31:0] dmem_mem [1024];
    bit          imem_seen [1024];
    bit          dmem_seen [1024];

    assign imem_rdata = imem_seen[imem_addr] ? imem_mem[imem_addr] : 32'h1000_0000 + 32'(imem_addr);
    assign dmem_rdata = dmem_seen[dmem_addr] ? dmem_mem[dmem_addr] : 32'h2000_0000 + 32'(dmem_addr);

    always @(posedge clk) begin
        if (imem_we) begin
            imem_mem[imem_addr]  <= imem_wdata;
            imem_seen[imem_addr] <= 1'b1;
        end
        if (dmem_we) begin
            dmem_mem[dmem_addr]  <= dmem_wdata;
            dmem_seen[dmem_addr] <= 1'b1;
        end
    end

    // Reference contents of the debug-visible words and last read result.
    logic [31:0] ref_imem [1024];
    logic [31:0] ref_dmem [1024];
    logic [31:0] last_rd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One debug transaction. pct is the per-cycle probability (%) that the
    // CPU uses dmem. Expected timeline: request in cycle 0, PEND from cycle
    // 1 until the first quiet CPU cycle or LIMIT lost cycles, LAT access
    // cycles, then a single response cycle.
    task automatic run_txn(input int pct, input bit is_wr, input bit both, input bit imem,
                           input logic [31:0] baddr, input logic [31:0] wdata, input bit inject,
                           output int obs_resp, output logic [31:0] obs_rdata,
                           output int obs_stalls, output int obs_pulses);
        bit           act [64];
        int           g, resp_c, word;
        bit           wr_op, in_acc, dbg_we_exp;
        logic [31:0]  exp_rd, exp_rdata;
        logic [AW-1:0] ci_addr, cd_addr;
        logic         cd_we;

        wr_op = is_wr || both;
        word  = int'(baddr[AW+1:2]);
        for (int i = 0; i < 64; i++) act[i] = ($urandom_range(0, 99) < pct);
        g = 0;
        if (!imem) while (g < LIMIT && act[1+g]) g++;
        resp_c = 2 + g + LAT;
        exp_rd = imem ? ref_imem[word] : ref_dmem[word];
        obs_resp = -1; obs_rdata = 'x; obs_stalls = 0; obs_pulses = 0;

        for (int c = 0; c <= resp_c + 1; c++) begin
            if (c == 0) begin
                dbg_addr     = baddr;
                dbg_wdata    = wdata;
                dbg_sel_imem = imem;
                dbg_wr_req   = wr_op;
                dbg_rd_req   = !is_wr || both;
            end else begin
                dbg_addr     = $urandom;
                dbg_wdata    = $urandom;
                dbg_sel_imem = 1'($urandom_range(0, 1));
                dbg_wr_req   = 1'b0;
                dbg_rd_req   = inject && (c == 2 || c == resp_c);
            end
            ci_addr        = AW'($urandom_range(1, 1023));
            cd_addr        = AW'(512 + $urandom_range(0, 511));
            cd_we          = act[c] && ($urandom_range(0, 1) == 1);
            cpu_imem_addr  = ci_addr;
            cpu_dmem_addr  = cd_addr;
            cpu_dmem_wdata = $urandom;
            cpu_dmem_we    = cd_we;
            cpu_dmem_re    = act[c] && !cd_we;

            @(negedge clk);
            in_acc     = (c >= 2 + g) && (c <= 1 + g + LAT);
            dbg_we_exp = in_acc && wr_op && (c == 2 + g);
            exp_rdata  = (c >= resp_c && !wr_op) ? exp_rd : last_rd;

            check($sformatf("busy@%0d", c), dbg_busy, (c >= 1 && c <= resp_c));
            check($sformatf("stall@%0d", c), cpu_stall,
                  (in_acc && (imem || act[c])) || (!imem && g == LIMIT && c == 1 + g && act[c]));
            check($sformatf("valid@%0d", c), dbg_rdata_valid, (c == resp_c && !wr_op));
            check($sformatf("done@%0d", c), dbg_wr_done, (c == resp_c && wr_op));
            check($sformatf("rdata@%0d", c), dbg_rdata, exp_rdata);
            check($sformatf("imem_addr@%0d", c), imem_addr, (in_acc && imem) ? word : ci_addr);
            check($sformatf("imem_we@%0d", c), imem_we, imem && dbg_we_exp);
            check($sformatf("dmem_addr@%0d", c), dmem_addr, (in_acc && !imem) ? word : cd_addr);
            check($sformatf("dmem_we@%0d", c), dmem_we, (in_acc && !imem) ? dbg_we_exp : cd_we);
            if (dbg_we_exp)
                check($sformatf("mem_wdata@%0d", c), imem ? imem_wdata : dmem_wdata, wdata);

            if (cpu_stall) obs_stalls++;
            if (dbg_rdata_valid || dbg_wr_done) begin
                obs_pulses++;
                if (obs_resp < 0) begin
                    obs_resp  = c;
                    obs_rdata = dbg_rdata;
                end
            end
            @(posedge clk); #1;
        end
        dbg_rd_req = 1'b0;
        cpu_dmem_we = 1'b0;
        cpu_dmem_re = 1'b0;

        if (wr_op) begin
            if (imem) ref_imem[word] = wdata;
            else      ref_dmem[word] = wdata;
        end else begin
            last_rd = exp_rd;
        end
    endtask

    typedef struct {
        int          pct;
        bit          wr;
        bit          both;
        bit          imem;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          inject;
        int          exp_resp;
        logic [31:0] exp_rd;
        int          exp_stalls;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int          r_resp, r_stalls, r_pulses;
        logic [31:0] r_rdata;

        rst_n = 1'b0;
        dbg_addr = '0; dbg_wdata = '0; dbg_rd_req = 1'b0; dbg_wr_req = 1'b0; dbg_sel_imem = 1'b0;
        cpu_imem_addr = 10'h155; cpu_dmem_addr = 10'h2AA; cpu_dmem_wdata = 32'h0;
        cpu_dmem_we = 1'b0; cpu_dmem_re = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ref_imem[i] = 32'h1000_0000 + 32'(i);
            ref_dmem[i] = 32'h2000_0000 + 32'(i);
        end
        last_rd = 32'h0;

        //            pct  wr  both imem addr          wdata         inj resp rd            stalls
        tbl[0] = '{   0,   1,  0,   0,   32'h0000_0010, 32'hDEADBEEF, 0,  3,   32'h0,        0};
        tbl[1] = '{   0,   0,  0,   0,   32'h0000_0010, 32'h0,        0,  3,   32'hDEADBEEF, 0};
        tbl[2] = '{   0,   0,  0,   1,   32'h0000_0000, 32'h0,        0,  3,   32'h1000_0000, 1};
        tbl[3] = '{ 100,   0,  0,   0,   32'h0000_0010, 32'h0,        0,  18,  32'hDEADBEEF, 2};
        tbl[4] = '{   0,   0,  0,   0,   32'h0000_0014, 32'h0,        1,  3,   32'h2000_0005, 0};
        tbl[5] = '{   0,   1,  1,   0,   32'h0000_0018, 32'h1234_5678, 0,  3,   32'h0,        0};
        tbl[6] = '{   0,   0,  0,   0,   32'hF000_0019, 32'h0,        0,  3,   32'h1234_5678, 0};
        tbl[7] = '{   0,   1,  0,   1,   32'h0000_0008, 32'hA5A5_0F0F, 0,  3,   32'h0,        1};
        tbl[8] = '{   0,   0,  0,   1,   32'h0000_0008, 32'h0,        1,  3,   32'hA5A5_0F0F, 1};

        #3;
        check("rst_busy", dbg_busy, 1'b0);
        check("rst_valid", dbg_rdata_valid, 1'b0);
        check("rst_done", dbg_wr_done, 1'b0);
        check("rst_rdata", dbg_rdata, 32'h0);
        check("rst_stall", cpu_stall, 1'b0);
        check("rst_imem_we", imem_we, 1'b0);
        check("rst_imem_addr", imem_addr, 10'h155);
        check("rst_dmem_addr", dmem_addr, 10'h2AA);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) begin
            run_txn(tbl[i].pct, tbl[i].wr, tbl[i].both, tbl[i].imem, tbl[i].addr, tbl[i].wdata,
                    tbl[i].inject, r_resp, r_rdata, r_stalls, r_pulses);
            check($sformatf("tbl%0d_resp_cycle", i), r_resp, tbl[i].exp_resp);
            check($sformatf("tbl%0d_pulses", i), r_pulses, 1);
            check($sformatf("tbl%0d_stalls", i), r_stalls, tbl[i].exp_stalls);
            if (!tbl[i].wr) check($sformatf("tbl%0d_rdata", i), r_rdata, tbl[i].exp_rd);
        end

        // Reset asserted during the access cycle of a dmem write.
        dbg_addr = 32'h0000_0080; dbg_wdata = 32'hCAFE_F00D; dbg_sel_imem = 1'b0; dbg_wr_req = 1'b1;
        @(posedge clk); #1;
        dbg_wr_req = 1'b0;
        @(posedge clk); #1;
        #1;
        check("abort_pre_we", dmem_we, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", dbg_busy, 1'b0);
        check("abort_stall", cpu_stall, 1'b0);
        check("abort_dmem_we", dmem_we, 1'b0);
        check("abort_dmem_addr", dmem_addr, cpu_dmem_addr);
        check("abort_rdata", dbg_rdata, 32'h0);
        check("abort_pulse", dbg_rdata_valid | dbg_wr_done, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_rd = 32'h0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("post_abort_done@%0d", c), dbg_wr_done, 1'b0);
            check($sformatf("post_abort_busy@%0d", c), dbg_busy, 1'b0);
            @(posedge clk); #1;
        end

        for (int t = 0; t < 60; t++) begin
            int          pct_sel, word;
            bit          wr, both, imem;
            logic [31:0] baddr;
            pct_sel = $urandom_range(0, 3);
            wr      = 1'($urandom_range(0, 1));
            both    = ($urandom_range(0, 7) == 0);
            imem    = ($urandom_range(0, 3) == 0);
            word    = $urandom_range(16'h40, 16'h1FF);
            baddr   = ($urandom & ~32'h0000_0FFC) | (32'(word) << 2);
            run_txn((pct_sel == 0) ? 0 : (pct_sel == 1) ? 50 : (pct_sel == 2) ? 90 : 100,
                    wr, both, imem, baddr, $urandom, ($urandom_range(0, 2) == 0),
                    r_resp, r_rdata, r_stalls, r_pulses);
            check($sformatf("rand%0d_pulses", t), r_pulses, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
